// File: rtl/encoder_pkg.sv
// Shared definitions for the instruction encoder: request opcodes, instruction
// opcode fields, immediate range limits and small packing helpers.
package encoder_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_AND    = 4'd2,
      OP_ORR    = 4'd3,
      OP_ADDI   = 4'd4,
      OP_SUBI   = 4'd5,
      OP_LDUR   = 4'd6,
      OP_STUR   = 4'd7,
      OP_B      = 4'd8,
      OP_CBZ    = 4'd9,
      OP_CBNZ   = 4'd10,
      OP_MOVI64 = 4'd11
   } req_op_t;

   // R-type opcodes
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   // I-type opcodes
   localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
   localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
   // D-type opcodes
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;
   // Branch opcodes
   localparam logic [5:0]  OPC_B    = 6'b000101;
   localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
   localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
   // Wide-move opcodes
   localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
   localparam logic [8:0]  OPC_MOVK = 9'b111100101;

   // Immediate range limits, checked against the full 64-bit request value
   localparam logic [63:0]        IMM12_LIMIT = 64'd4096;
   localparam logic signed [63:0] DT9_MIN     = -64'sd256;
   localparam logic signed [63:0] DT9_MAX     = 64'sd255;
   localparam logic signed [63:0] BR19_MIN    = -64'sd262144;
   localparam logic signed [63:0] BR19_MAX    = 64'sd262143;
   localparam logic signed [63:0] BR26_MIN    = -64'sd33554432;
   localparam logic signed [63:0] BR26_MAX    = 64'sd33554431;

   // Build an IW-format word (MOVZ / MOVK)
   function automatic logic [31:0] pack_iw(input logic [8:0]  opcode,
                                           input logic [1:0]  hw,
                                           input logic [15:0] imm16,
                                           input logic [4:0]  rd);
      return {opcode, hw, imm16, rd};
   endfunction

   // True when the two's-complement value lies inside [lo, hi]
   function automatic logic in_signed_range(input logic [63:0]        value,
                                            input logic signed [63:0] lo,
                                            input logic signed [63:0] hi);
      return ($signed(value) >= lo) && ($signed(value) <= hi);
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: maps one request (op + register fields +
// immediate) to its first 32-bit instruction word and reports whether the
// immediate fits the target field. Illegal ops report range_ok = 0.
module instr_field_pack
   import encoder_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rn,
   input  logic [4:0]  rm,
   input  logic [63:0] imm,
   output logic [31:0] word,
   output logic        range_ok
);

   // Select the field layout for the op and check the immediate against its field
   always_comb begin
      word     = 32'd0;
      range_ok = 1'b0;
      case (op)
         OP_ADD: begin
            word     = {OPC_ADD, rm, 6'd0, rn, rd};
            range_ok = 1'b1;
         end
         OP_SUB: begin
            word     = {OPC_SUB, rm, 6'd0, rn, rd};
            range_ok = 1'b1;
         end
         OP_AND: begin
            word     = {OPC_AND, rm, 6'd0, rn, rd};
            range_ok = 1'b1;
         end
         OP_ORR: begin
            word     = {OPC_ORR, rm, 6'd0, rn, rd};
            range_ok = 1'b1;
         end
         OP_ADDI: begin
            word     = {OPC_ADDI, imm[11:0], rn, rd};
            range_ok = (imm < IMM12_LIMIT);
         end
         OP_SUBI: begin
            word     = {OPC_SUBI, imm[11:0], rn, rd};
            range_ok = (imm < IMM12_LIMIT);
         end
         OP_LDUR: begin
            word     = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
            range_ok = in_signed_range(imm, DT9_MIN, DT9_MAX);
         end
         OP_STUR: begin
            word     = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
            range_ok = in_signed_range(imm, DT9_MIN, DT9_MAX);
         end
         OP_B: begin
            word     = {OPC_B, imm[25:0]};
            range_ok = in_signed_range(imm, BR26_MIN, BR26_MAX);
         end
         OP_CBZ: begin
            word     = {OPC_CBZ, imm[18:0], rd};
            range_ok = in_signed_range(imm, BR19_MIN, BR19_MAX);
         end
         OP_CBNZ: begin
            word     = {OPC_CBNZ, imm[18:0], rd};
            range_ok = in_signed_range(imm, BR19_MIN, BR19_MAX);
         end
         OP_MOVI64: begin
            // First word of the expansion is always MOVZ of the low halfword
            word     = pack_iw(OPC_MOVZ, 2'd0, imm[15:0], rd);
            range_ok = 1'b1;
         end
         default: begin
            word     = 32'd0;
            range_ok = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts abstract operation requests and emits 32-bit
// instruction words through a single output register. A 64-bit constant load
// expands into MOVZ followed by one MOVK per nonzero upper halfword.
module instr_encoder
   import encoder_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rn,
   input  logic [4:0]  req_rm,
   input  logic [63:0] req_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_last,
   output logic        err
);

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_EXPAND = 1'b1;

   logic        state;
   logic [4:0]  hold_rd;
   logic [47:0] hold_imm;     // halfwords 1..3 of the constant being expanded
   logic [2:0]  mask;         // bit k-1 set: MOVK for halfword k still pending

   logic [31:0] first_word;
   logic        range_ok;
   logic        accept;
   logic        out_fire;
   logic        is_movi;
   logic [2:0]  first_mask;
   logic [1:0]  next_hw;
   logic [15:0] next_half;
   logic [2:0]  mask_after;
   logic [31:0] movk_word;

   instr_field_pack u_pack (
      .op       (req_op),
      .rd       (req_rd),
      .rn       (req_rn),
      .rm       (req_rm),
      .imm      (req_imm),
      .word     (first_word),
      .range_ok (range_ok)
   );

   // Ready depends only on state and the output register handshake, never on req_valid
   always_comb begin
      req_ready = 1'b0;
      if (state == ST_IDLE) begin
         req_ready = ~out_valid | out_ready;
      end else begin
         req_ready = 1'b0;
      end
   end

   assign accept     = req_valid & req_ready;
   assign out_fire   = out_valid & out_ready;
   assign is_movi    = (req_op == OP_MOVI64);
   assign first_mask = {|req_imm[63:48], |req_imm[47:32], |req_imm[31:16]};

   // Pick the lowest pending halfword and build its MOVK word
   always_comb begin
      next_hw   = 2'd3;
      next_half = hold_imm[47:32];
      if (mask[0]) begin
         next_hw   = 2'd1;
         next_half = hold_imm[15:0];
      end else if (mask[1]) begin
         next_hw   = 2'd2;
         next_half = hold_imm[31:16];
      end else begin
         next_hw   = 2'd3;
         next_half = hold_imm[47:32];
      end
      mask_after = mask & (mask - 3'd1);
      movk_word  = pack_iw(OPC_MOVK, next_hw, next_half, hold_rd);
   end

   // Output register, expansion sequencing and the one-cycle reject pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_last  <= 1'b0;
         err       <= 1'b0;
         hold_rd   <= 5'd0;
         hold_imm  <= 48'd0;
         mask      <= 3'd0;
      end else begin
         err <= accept & ~range_ok;
         case (state)
            ST_IDLE: begin
               if (accept && range_ok) begin
                  out_valid <= 1'b1;
                  out_instr <= first_word;
                  if (is_movi && (first_mask != 3'd0)) begin
                     out_last <= 1'b0;
                     hold_rd  <= req_rd;
                     hold_imm <= req_imm[63:16];
                     mask     <= first_mask;
                     state    <= ST_EXPAND;
                  end else begin
                     out_last <= 1'b1;
                  end
               end else if (out_fire) begin
                  out_valid <= 1'b0;
               end
            end
            ST_EXPAND: begin
               // out_valid stays high for the whole expansion
               if (out_fire) begin
                  out_instr <= movk_word;
                  mask      <= mask_after;
                  out_last  <= (mask_after == 3'd0);
                  if (mask_after == 3'd0) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the stimulus side pushes expected words
// computed by an arithmetic reference model; a negedge monitor pops and
// compares on every output handshake and accounts for err pulses.
module tb_instr_encoder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [4:0]  req_rd;
   logic [4:0]  req_rn;
   logic [4:0]  req_rm;
   logic [63:0] req_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        err;

   int  mode = 1;          // 0 random out_ready, 1 always ready, 2 never ready
   bit  rnd_ready = 1'b1;
   int  checks = 0;
   int  errors = 0;
   int  err_pending = 0;
   logic [32:0] exp_q[$];  // {last, instr}

   int r_opc[4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
   logic [63:0] bnd_tab[17] = '{64'd4095, 64'd4096, 64'd0, -64'sd256, -64'sd257, 64'd255, 64'd256,
                                64'd33554431, 64'd33554432, -64'sd33554432, -64'sd33554433,
                                64'd262143, 64'd262144, -64'sd262144, -64'sd262145,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};

   instr_encoder dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_rd    (req_rd),
      .req_rn    (req_rn),
      .req_rm    (req_rm),
      .req_imm   (req_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_last  (out_last),
      .err       (err)
   );

   always #5 clock = ~clock;

   assign out_ready = (mode == 1) || ((mode == 0) && rnd_ready);

   always @(posedge clock) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   function automatic longint wrap(input longint v, input longint m);
      return ((v % m) + m) % m;
   endfunction

   // Reference model: the words a request should produce, or a pending err
   task automatic model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [63:0] imm);
      longint s;
      longint unsigned u;
      longint w;
      bit bad;
      logic [31:0] words[$];
      logic [31:0] one;
      longint h;
      s = $signed(imm);
      u = imm;
      bad = 1'b0;
      w = 0;
      case (int'(op))
         0, 1, 2, 3: begin
            w = longint'(r_opc[op]) * 2097152 + longint'(rm) * 65536 + longint'(rn) * 32 + longint'(rd);
            one = w[31:0]; words.push_back(one);
         end
         4, 5: begin
            bad = (u >= 64'd4096);
            w = longint'((op == 4'd4) ? 580 : 836) * 4194304 + longint'(u % 4096) * 1024
                + longint'(rn) * 32 + longint'(rd);
            one = w[31:0]; words.push_back(one);
         end
         6, 7: begin
            bad = (s < -256) || (s > 255);
            w = longint'((op == 4'd6) ? 1986 : 1984) * 2097152 + wrap(s, 512) * 4096
                + longint'(rn) * 32 + longint'(rd);
            one = w[31:0]; words.push_back(one);
         end
         8: begin
            bad = (s < -33554432) || (s > 33554431);
            w = 5 * 67108864 + wrap(s, 67108864);
            one = w[31:0]; words.push_back(one);
         end
         9, 10: begin
            bad = (s < -262144) || (s > 262143);
            w = longint'((op == 4'd9) ? 180 : 181) * 16777216 + wrap(s, 524288) * 32 + longint'(rd);
            one = w[31:0]; words.push_back(one);
         end
         11: begin
            h = longint'(u % 65536);
            w = 421 * 8388608 + h * 32 + longint'(rd);
            one = w[31:0]; words.push_back(one);
            for (int k = 1; k < 4; k++) begin
               h = longint'((u >> (16 * k)) % 65536);
               if (h != 0) begin
                  w = 485 * 8388608 + longint'(k) * 2097152 + h * 32 + longint'(rd);
                  one = w[31:0]; words.push_back(one);
               end
            end
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         err_pending++;
      end else begin
         for (int i = 0; i < words.size(); i++) begin
            exp_q.push_back({(i == words.size() - 1) ? 1'b1 : 1'b0, words[i]});
         end
      end
   endtask

   // Present one request and hold it until accepted; returns at accept edge + 1
   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [63:0] imm, output int waited);
      bit got;
      req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm;
      req_valid = 1'b1;
      waited = 0;
      got = 1'b0;
      while (!got && waited <= 500) begin
         @(negedge clock);
         if (req_ready) got = 1'b1;
         else waited++;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout: actual no accept after %0d cycles required accept", waited);
      end else begin
         model(op, rd, rn, rm, imm);
         @(posedge clock);
         #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      mode = 1;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [63:0] rand_imm();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = {$urandom, $urandom};
         1: v = 64'($urandom_range(0, 5000));
         2: v = 64'(-longint'($urandom_range(0, 400)));
         3: v = bnd_tab[$urandom_range(0, 16)];
         4: begin
            v = {$urandom, $urandom};
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) v[16*k +: 16] = 16'd0;
         end
         default: v = 64'(longint'($urandom_range(0, 134217727)) - 67108864);
      endcase
      return v;
   endfunction

   // Monitor: compare each handshaken word, account for err pulses, check stalls
   logic        stall_prev = 1'b0;
   logic [31:0] prev_instr = 32'd0;
   logic        prev_last = 1'b0;
   always @(negedge clock) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_instr", 64'(out_instr), 64'(prev_instr));
            check("stall_last", 64'(out_last), 64'(prev_last));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_word: actual 0x%08h required no word", out_instr);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               check("word", 64'(out_instr), 64'(e[31:0]));
               check("last", 64'(out_last), 64'(e[32]));
            end
         end
         if (err) begin
            checks++;
            if (err_pending > 0) begin
               err_pending--;
            end else begin
               errors++;
               $display("FAIL unexpected_err: actual err=1 required err=0");
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_instr = out_instr;
         prev_last  = out_last;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int waited;
      reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_rd = 5'd0; req_rn = 5'd0;
      req_rm = 5'd0; req_imm = 64'd0; mode = 1;
      repeat (3) @(posedge clock);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_instr", 64'(out_instr), 64'd0);
      check("reset_out_last", 64'(out_last), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd1);
      reset = 1'b0;
      @(posedge clock); #1;

      // ADD: one word, one cycle after accept
      send(4'd0, 5'd1, 5'd2, 5'd3, 64'd0, waited);
      check("add_valid", 64'(out_valid), 64'd1);
      check("add_instr", 64'(out_instr), 64'h8B030041);
      check("add_last", 64'(out_last), 64'd1);

      // MOVI64 with halfwords 0 and 3 set
      drain();
      send(4'd11, 5'd5, 5'd0, 5'd0, 64'h0001_0000_0000_ABCD, waited);
      check("movz_instr", 64'(out_instr), 64'hD29579A5);
      check("movz_last", 64'(out_last), 64'd0);
      check("movz_req_ready", 64'(req_ready), 64'd0);
      @(posedge clock); #1;
      check("movk_instr", 64'(out_instr), 64'hF2E00025);
      check("movk_last", 64'(out_last), 64'd1);

      // LDUR at the lower offset bound, then ADDI just out of range
      drain();
      send(4'd6, 5'd0, 5'd1, 5'd0, -64'sd256, waited);
      check("ldur_instr", 64'(out_instr), 64'hF8500020);
      send(4'd4, 5'd2, 5'd3, 5'd0, 64'd4096, waited);
      check("addi_err_pulse", 64'(err), 64'd1);
      check("addi_no_valid", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      check("addi_err_one_cycle", 64'(err), 64'd0);

      // B with back-pressure: word holds, no new request taken
      drain();
      mode = 2;
      send(4'd8, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, waited);
      check("b_instr", 64'(out_instr), 64'h17FFFFFF);
      repeat (3) begin
         @(negedge clock);
         check("b_hold_instr", 64'(out_instr), 64'h17FFFFFF);
         check("b_hold_req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clock); #1;
      mode = 1;
      send(4'd0, 5'd4, 5'd5, 5'd6, 64'd0, waited);
      check("release_accept_wait", 64'(waited), 64'd0);
      check("release_instr", 64'(out_instr), 64'h8B0600A4);
      check("release_valid", 64'(out_valid), 64'd1);

      // MOVI64 of zero: lone MOVZ
      drain();
      send(4'd11, 5'd7, 5'd0, 5'd0, 64'd0, waited);
      check("movi0_instr", 64'(out_instr), 64'hD2800007);
      check("movi0_last", 64'(out_last), 64'd1);

      // Reset in the middle of an all-ones expansion
      drain();
      send(4'd11, 5'd9, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, waited);
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("expand_req_ready", 64'(req_ready), 64'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_q.delete();
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_req_ready", 64'(req_ready), 64'd1);
      repeat (4) begin
         @(negedge clock);
         check("abort_no_more_words", 64'(out_valid), 64'd0);
      end
      @(posedge clock); #1;

      // Randomized traffic with random back-pressure
      mode = 0;
      for (int i = 0; i < 400; i++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         send(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), rand_imm(), waited);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
         end
      end

      drain();
      @(posedge clock); #1;
      check("final_err_pending", 64'(err_pending), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder for the multicycle core: the inverse of the control unit's instruction decoder. It accepts abstract operation requests (op, registers, 64-bit immediate) over a valid/ready handshake and emits 32-bit instruction words in the same bit layout the control unit decodes. Instruction classes are DP-reg, DP-imm, load/store, branch and wide-move. A 64-bit constant load is expanded into a MOVZ plus MOVK sequence over several cycles. The block sits between the test/program generator and instruction memory (program loader path).

## Interface
- No parameters.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 ADDI, 5 SUBI, 6 LDUR, 7 STUR, 8 B, 9 CBZ, 10 CBNZ, 11 MOVI64, 12–15 illegal
- req_rd  in  5  destination register / Rt
- req_rn  in  5  first source / base register
- req_rm  in  5  second source register
- req_imm  in  64  immediate or offset (two's complement where signed)
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_instr  out  32  encoded instruction word
- out_last  out  1  final word of the current request
- err  out  1  one-cycle pulse: request accepted but rejected (illegal op or immediate out of range)

## Operation
- Field layouts:
  - R-type: [31:21] opcode, [20:16] rm, [15:10] shamt=0, [9:5] rn, [4:0] rd.
  - I-type: [31:22] opcode, [21:10] imm12, [9:5] rn, [4:0] rd.
  - D-type: [31:21] opcode, [20:12] dt9, [11:10]=00, [9:5] rn, [4:0] rt.
  - B: [31:26] opcode, [25:0] br26.
  - CB: [31:24] opcode, [23:5] cond19, [4:0] rt=rd.
  - IW: [31:23] opcode, [22:21] hw, [20:5] imm16, [4:0] rd.
- Opcodes:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - ADDI 1001000100, SUBI 1101000100.
  - LDUR 11111000010, STUR 11111000000.
  - B 000101, CBZ 10110100, CBNZ 10110101.
  - MOVZ 110100101, MOVK 111100101.
- Range checks:
  - ADDI/SUBI: req_imm unsigned < 4096.
  - LDUR/STUR: −256..255.
  - B: fits signed 26 bits.
  - CBZ/CBNZ: fits signed 19 bits.
  - Range is checked on the full 64-bit value.
  - On failure, or for an illegal op: err=1 for the cycle after accept, no word emitted, state stays IDLE.
- req_imm is ignored for ops 0–3; req_rm is ignored for all ops except 0–3.
- MOVI64 expansion:
  - Word 1 is always MOVZ rd, imm[15:0], hw=0, even when that halfword is zero.
  - Then one MOVK rd, imm[16k+15:16k], hw=k for each k=1..3 whose halfword is nonzero, in ascending k.
  - out_last is set on the final word.
  - All single-word ops assert out_last=1.
- FSM states:
  - IDLE: req_ready = ~out_valid | out_ready. On accept, load out_instr with word 1.
    - If more MOVK words remain, latch rd plus a remaining-halfword mask and go to EXPAND.
  - EXPAND: req_ready=0. On each out_ready handshake, load the next MOVK.
    - Return to IDLE with the handshake that loads the last word.
- Output register: out_instr/out_last hold stable while out_valid & ~out_ready.
- Reset values: out_valid=0, out_instr=0, out_last=0, err=0, state IDLE.
- Reset during EXPAND abandons the sequence; no further words are emitted.

## Timing
- Latency: accept at cycle N → out_valid at N+1. err pulses at N+1.
- Throughput: one word per cycle while out_ready=1, including back-to-back single-word requests and MOVK words.
- Simultaneous out handshake and new accept in IDLE: the register is replaced, out_valid stays 1.
- req_ready is combinational from state, out_valid and out_ready only. There is no path from req_valid to req_ready.

## Structure
- Shared package encoder_pkg holds:
  - the req_op enumeration;
  - all opcode constants;
  - the range limits: 4096, 9-bit, 19-bit and 26-bit signed bounds.
- One combinational sub-module, instr_field_pack: op + fields → 32-bit word plus range_ok. The FSM, output register and halfword mask live in the top.

## Test plan
- ADD rd=1, rn=2, rm=3 → one word 0x8B030041, out_last=1, one cycle after accept.
- MOVI64 rd=5, imm=0x0001_0000_0000_ABCD → 0xD29579A5, then 0xF2E00025 with out_last=1. req_ready=0 between the two words.
- LDUR rd=0, rn=1, imm=−256 → 0xF8500020. Then ADDI imm=4096 → err pulse, no out_valid.
- B imm=−1 → 0x17FFFFFF. Hold out_ready=0 for 3 cycles → word stable, req_ready=0; release → next request accepted in the same cycle.
- MOVI64 imm=0 → only MOVZ 0xD2800000|rd, with out_last=1.
- Assert reset during EXPAND of imm=0xFFFF_FFFF_FFFF_FFFF after the second word → out_valid=0 next cycle, no further MOVK words, req_ready=1.
